// File: rtl/game_pkg.sv
// Shared types and constants for the frogger game sequencer, frog mover and renderer.
package game_pkg;

   typedef enum logic [1:0] {
      MENU    = 2'd0,
      PLAYING = 2'd1,
      DEAD    = 2'd2,
      WIN     = 2'd3
   } game_state_t;

   localparam int SCORE_MAX = 9999;
   localparam int FRAME_HZ  = 60;

   localparam int LIVES_W = 3;
   localparam int LEVEL_W = 3;
   localparam int SCORE_W = 14;
   localparam int TIMER_W = 11;
   localparam int HOLD_W  = 8;

endpackage

// File: rtl/game_controller_if.sv
// Game controller signal bundle: event inputs from detectors/buttons, status outputs to frog/lanes/HUD.
interface game_controller_if;
   import game_pkg::*;

   logic                frame_tick;
   logic                btn_start_tick;
   logic                collision;
   logic                reached_end;
   game_state_t         state;
   logic                frog_rst;
   logic [LIVES_W-1:0]  lives;
   logic [LEVEL_W-1:0]  level;
   logic [SCORE_W-1:0]  score;
   logic [TIMER_W-1:0]  timer;
   logic                game_over;

   modport master (
      output frame_tick, btn_start_tick, collision, reached_end,
      input  state, frog_rst, lives, level, score, timer, game_over
   );

   modport slave (
      input  frame_tick, btn_start_tick, collision, reached_end,
      output state, frog_rst, lives, level, score, timer, game_over
   );

endinterface

// File: rtl/frame_countdown.sv
// Loadable down-counter stepped by frame ticks; expire flags the tick that takes it from 1 to 0.
module frame_countdown #(
   parameter int                WIDTH   = 8,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              tick,
   output logic [WIDTH-1:0]  count,
   output logic              expire
);

   logic [WIDTH-1:0] r_count;

   // load wins over tick; the counter parks at zero rather than wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= RST_VAL;
      end else if (load) begin
         r_count <= load_val;
      end else if (tick && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign count  = r_count;
   assign expire = tick && (r_count == WIDTH'(1));

endmodule

// File: rtl/game_controller.sv
// Frogger game sequencer: MENU/PLAYING/DEAD/WIN flow, lives, level, score and per-life timer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MENU    | idle / game over; waits for start press
// PLAYING | frog live; life timer runs; watches collision/goal/timeout
// DEAD    | death hold; then respawn or game over
// WIN     | goal hold; then next level respawn
module game_controller
   import game_pkg::*;
#(
   parameter int LIVES       = 3,
   parameter int TIME_LIMIT  = 1800,
   parameter int DEAD_HOLD   = 90,
   parameter int WIN_HOLD    = 120,
   parameter int MAX_LEVEL   = 7,
   parameter int GOAL_POINTS = 50
) (
   input  logic               clk,
   input  logic               reset,
   game_controller_if.slave   bus
);

   game_state_t         r_state, w_state_nxt;
   logic [LIVES_W-1:0]  r_lives, w_lives_nxt;
   logic [LEVEL_W-1:0]  r_level, w_level_nxt;
   logic [SCORE_W-1:0]  r_score, w_score_nxt;
   logic                r_game_over, w_game_over_nxt;
   logic                r_frog_rst, w_frog_rst_nxt;

   logic                w_tmr_load, w_tmr_tick, w_tmr_expire;
   logic [TIMER_W-1:0]  w_timer;
   logic                w_hold_load, w_hold_tick, w_hold_expire;
   logic [HOLD_W-1:0]   w_hold_val;
   // hold exit comes from expire; the raw count is not needed here
   logic [HOLD_W-1:0]   w_hold_count_unused;

   logic [15:0]         w_goal_sum;
   logic [SCORE_W-1:0]  w_score_sat;

   frame_countdown #(
      .WIDTH   (TIMER_W),
      .RST_VAL (TIMER_W'(TIME_LIMIT))
   ) u_life_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_tmr_load),
      .load_val (TIMER_W'(TIME_LIMIT)),
      .tick     (w_tmr_tick),
      .count    (w_timer),
      .expire   (w_tmr_expire)
   );

   frame_countdown #(
      .WIDTH   (HOLD_W),
      .RST_VAL ('0)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (w_hold_load),
      .load_val (w_hold_val),
      .tick     (w_hold_tick),
      .count    (w_hold_count_unused),
      .expire   (w_hold_expire)
   );

   // 16-bit sum covers 9999 + 50*8 before the clamp
   assign w_goal_sum  = 16'(r_score) + 16'(GOAL_POINTS) * (16'(r_level) + 16'd1);
   assign w_score_sat = (w_goal_sum > 16'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : SCORE_W'(w_goal_sum);

   always_comb begin
      w_state_nxt     = r_state;
      w_lives_nxt     = r_lives;
      w_level_nxt     = r_level;
      w_score_nxt     = r_score;
      w_game_over_nxt = r_game_over;
      w_frog_rst_nxt  = 1'b0;
      w_tmr_load      = 1'b0;
      w_hold_load     = 1'b0;
      w_hold_val      = '0;
      w_tmr_tick      = bus.frame_tick && (r_state == PLAYING);
      w_hold_tick     = bus.frame_tick && ((r_state == DEAD) || (r_state == WIN));

      case (r_state)
         MENU: begin
            if (bus.btn_start_tick) begin
               w_state_nxt     = PLAYING;
               w_lives_nxt     = LIVES_W'(LIVES);
               w_level_nxt     = '0;
               w_score_nxt     = '0;
               w_game_over_nxt = 1'b0;
               w_tmr_load      = 1'b1;
               w_frog_rst_nxt  = 1'b1;
            end
         end
         PLAYING: begin
            // a goal in the same cycle as a timeout still counts as a goal
            if (bus.collision || (!bus.reached_end && w_tmr_expire)) begin
               w_state_nxt = DEAD;
               w_lives_nxt = (r_lives != '0) ? r_lives - LIVES_W'(1) : '0;
               w_hold_load = 1'b1;
               w_hold_val  = HOLD_W'(DEAD_HOLD);
            end else if (bus.reached_end) begin
               w_state_nxt = WIN;
               w_score_nxt = w_score_sat;
               w_level_nxt = (r_level < LEVEL_W'(MAX_LEVEL)) ? r_level + LEVEL_W'(1) : r_level;
               w_hold_load = 1'b1;
               w_hold_val  = HOLD_W'(WIN_HOLD);
            end
         end
         DEAD: begin
            if (w_hold_expire) begin
               if (r_lives != '0) begin
                  w_state_nxt    = PLAYING;
                  w_tmr_load     = 1'b1;
                  w_frog_rst_nxt = 1'b1;
               end else begin
                  w_state_nxt     = MENU;
                  w_game_over_nxt = 1'b1;
               end
            end
         end
         WIN: begin
            if (w_hold_expire) begin
               w_state_nxt    = PLAYING;
               w_tmr_load     = 1'b1;
               w_frog_rst_nxt = 1'b1;
            end
         end
         default: w_state_nxt = MENU;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= MENU;
         r_lives     <= LIVES_W'(LIVES);
         r_level     <= '0;
         r_score     <= '0;
         r_game_over <= 1'b0;
         r_frog_rst  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_lives     <= w_lives_nxt;
         r_level     <= w_level_nxt;
         r_score     <= w_score_nxt;
         r_game_over <= w_game_over_nxt;
         r_frog_rst  <= w_frog_rst_nxt;
      end
   end

   assign bus.state     = r_state;
   assign bus.frog_rst  = r_frog_rst;
   assign bus.lives     = r_lives;
   assign bus.level     = r_level;
   assign bus.score     = r_score;
   assign bus.timer     = w_timer;
   assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios plus random play against a rule model.
module tb_game_controller;
   import game_pkg::*;

   localparam int LIVES = 3;
   localparam int TL    = 12;
   localparam int DH    = 5;
   localparam int WH    = 6;
   localparam int MAXL  = 7;
   localparam int GP    = 50;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   game_controller_if gif();

   game_controller #(
      .LIVES(LIVES), .TIME_LIMIT(TL), .DEAD_HOLD(DH), .WIN_HOLD(WH),
      .MAX_LEVEL(MAXL), .GOAL_POINTS(GP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (gif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // rule model: 0=menu 1=playing 2=dead 3=win
   int m_state, m_lives, m_level, m_score, m_timer, m_hold, m_go, m_frog;

   task automatic model_reset();
      m_state = 0; m_lives = LIVES; m_level = 0; m_score = 0;
      m_timer = TL; m_hold = 0; m_go = 0; m_frog = 0;
   endtask

   task automatic model_step(input bit st, input bit ft, input bit col, input bit rch);
      bit tout;
      tout   = 1'b0;
      m_frog = 0;
      case (m_state)
         0: if (st) begin
            m_state = 1; m_lives = LIVES; m_level = 0; m_score = 0;
            m_timer = TL; m_go = 0; m_frog = 1;
         end
         1: begin
            if (ft) begin
               tout = (m_timer == 1);
               if (m_timer > 0) m_timer--;
            end
            if (col || (!rch && tout)) begin
               m_lives = (m_lives > 0) ? m_lives - 1 : 0;
               m_hold  = DH; m_state = 2;
            end else if (rch) begin
               m_score = m_score + GP * (m_level + 1);
               if (m_score > SCORE_MAX) m_score = SCORE_MAX;
               if (m_level < MAXL) m_level++;
               m_hold = WH; m_state = 3;
            end
         end
         default: if (ft) begin
            if (m_hold == 1) begin
               m_hold = 0;
               if (m_state == 3 || m_lives > 0) begin
                  m_state = 1; m_timer = TL; m_frog = 1;
               end else begin
                  m_state = 0; m_go = 1;
               end
            end else begin
               m_hold--;
            end
         end
      endcase
   endtask

   task automatic drive(input bit st, input bit ft, input bit col, input bit rch);
      @(negedge clk);
      gif.btn_start_tick = st; gif.frame_tick = ft; gif.collision = col; gif.reached_end = rch;
      @(posedge clk);
      #1;
      model_step(st, ft, col, rch);
   endtask

   task automatic hold_frames(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (gif.state !== MENU) begin n_errors++; $display("FAIL reset_state got %0d want 0", gif.state); end
      n_checks++; if (gif.frog_rst !== 1'b0) begin n_errors++; $display("FAIL reset_frog_rst got %0b want 0", gif.frog_rst); end
      n_checks++; if (gif.lives !== 3'(LIVES)) begin n_errors++; $display("FAIL reset_lives got %0d want %0d", gif.lives, LIVES); end
      n_checks++; if (gif.level !== 3'd0) begin n_errors++; $display("FAIL reset_level got %0d want 0", gif.level); end
      n_checks++; if (gif.score !== 14'd0) begin n_errors++; $display("FAIL reset_score got %0d want 0", gif.score); end
      n_checks++; if (gif.timer !== 11'(TL)) begin n_errors++; $display("FAIL reset_timer got %0d want %0d", gif.timer, TL); end
      n_checks++; if (gif.game_over !== 1'b0) begin n_errors++; $display("FAIL reset_game_over got %0b want 0", gif.game_over); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_start();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (gif.state !== PLAYING) begin n_errors++; $display("FAIL start_state got %0d want 1", gif.state); end
      n_checks++; if (gif.frog_rst !== 1'b1) begin n_errors++; $display("FAIL start_frog_rst got %0b want 1", gif.frog_rst); end
      n_checks++; if (gif.lives !== 3'd3) begin n_errors++; $display("FAIL start_lives got %0d want 3", gif.lives); end
      n_checks++; if (gif.timer !== 11'(TL)) begin n_errors++; $display("FAIL start_timer got %0d want %0d", gif.timer, TL); end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (gif.frog_rst !== 1'b0) begin n_errors++; $display("FAIL start_frog_rst_width got %0b want 0", gif.frog_rst); end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (gif.timer !== 11'(TL - 1)) begin n_errors++; $display("FAIL first_tick_timer got %0d want %0d", gif.timer, TL - 1); end
   endtask

   task automatic test_death_priority();
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      n_checks++; if (gif.state !== DEAD) begin n_errors++; $display("FAIL colgoal_state got %0d want 2", gif.state); end
      n_checks++; if (gif.lives !== 3'd2) begin n_errors++; $display("FAIL colgoal_lives got %0d want 2", gif.lives); end
      n_checks++; if (gif.score !== 14'd0) begin n_errors++; $display("FAIL colgoal_score got %0d want 0", gif.score); end
      n_checks++; if (gif.frog_rst !== 1'b0) begin n_errors++; $display("FAIL death_frog_rst got %0b want 0", gif.frog_rst); end
      for (int i = 0; i < DH; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b1);
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         if (i < DH - 1) begin
            n_checks++; if (gif.state !== DEAD || gif.lives !== 3'd2) begin n_errors++; $display("FAIL dead_hold got state %0d lives %0d want 2/2", gif.state, gif.lives); end
         end
      end
      n_checks++; if (gif.state !== PLAYING) begin n_errors++; $display("FAIL respawn_state got %0d want 1", gif.state); end
      n_checks++; if (gif.frog_rst !== 1'b1) begin n_errors++; $display("FAIL respawn_frog_rst got %0b want 1", gif.frog_rst); end
      n_checks++; if (gif.timer !== 11'(TL)) begin n_errors++; $display("FAIL respawn_timer got %0d want %0d", gif.timer, TL); end
   endtask

   task automatic test_goals();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (gif.state !== WIN) begin n_errors++; $display("FAIL goal1_state got %0d want 3", gif.state); end
      n_checks++; if (gif.score !== 14'd50 || gif.level !== 3'd1) begin n_errors++; $display("FAIL goal1 got score %0d level %0d want 50/1", gif.score, gif.level); end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      hold_frames(WH - 2);
      n_checks++; if (gif.state !== WIN) begin n_errors++; $display("FAIL win_hold got %0d want 3", gif.state); end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (gif.state !== PLAYING || gif.frog_rst !== 1'b1 || gif.timer !== 11'(TL)) begin
         n_errors++; $display("FAIL win_exit got state %0d frog_rst %0b timer %0d want 1/1/%0d", gif.state, gif.frog_rst, gif.timer, TL); end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (gif.score !== 14'd150 || gif.level !== 3'd2) begin n_errors++; $display("FAIL goal2 got score %0d level %0d want 150/2", gif.score, gif.level); end
      hold_frames(WH);
      n_checks++; if (gif.state !== PLAYING || gif.timer !== 11'(TL)) begin n_errors++; $display("FAIL win2_exit got state %0d timer %0d want 1/%0d", gif.state, gif.timer, TL); end
   endtask

   task automatic test_timeout();
      for (int i = 1; i <= TL; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         if (i < TL) begin
            n_checks++; if (gif.state !== PLAYING || gif.timer !== 11'(TL - i)) begin
               n_errors++; $display("FAIL timer_run got state %0d timer %0d want 1/%0d", gif.state, gif.timer, TL - i); end
         end
      end
      n_checks++; if (gif.state !== DEAD || gif.lives !== 3'd1 || gif.timer !== 11'd0) begin
         n_errors++; $display("FAIL timeout got state %0d lives %0d timer %0d want 2/1/0", gif.state, gif.lives, gif.timer); end
   endtask

   task automatic test_game_over();
      hold_frames(DH);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++; if (gif.state !== DEAD || gif.lives !== 3'd0) begin n_errors++; $display("FAIL last_death got state %0d lives %0d want 2/0", gif.state, gif.lives); end
      hold_frames(DH);
      n_checks++; if (gif.state !== MENU || gif.game_over !== 1'b1 || gif.frog_rst !== 1'b0) begin
         n_errors++; $display("FAIL game_over got state %0d go %0b frog_rst %0b want 0/1/0", gif.state, gif.game_over, gif.frog_rst); end
      n_checks++; if (gif.score !== 14'd150 || gif.level !== 3'd2) begin n_errors++; $display("FAIL hud_hold got score %0d level %0d want 150/2", gif.score, gif.level); end
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      n_checks++; if (gif.state !== MENU || gif.game_over !== 1'b1) begin n_errors++; $display("FAIL menu_ignore got state %0d go %0b want 0/1", gif.state, gif.game_over); end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (gif.game_over !== 1'b0 || gif.lives !== 3'd3 || gif.score !== 14'd0 || gif.level !== 3'd0) begin
         n_errors++; $display("FAIL restart got go %0b lives %0d score %0d level %0d want 0/3/0/0", gif.game_over, gif.lives, gif.score, gif.level); end
   endtask

   task automatic test_score_saturation();
      int exp_score, exp_level;
      exp_score = 0; exp_level = 0;
      for (int g = 0; g < 30; g++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1);
         exp_score = exp_score + GP * (exp_level + 1);
         if (exp_score > 9999) exp_score = 9999;
         if (exp_level < MAXL) exp_level++;
         n_checks++; if (gif.score !== 14'(exp_score) || gif.level !== 3'(exp_level)) begin
            n_errors++; $display("FAIL goal_seq%0d got score %0d level %0d want %0d/%0d", g, gif.score, gif.level, exp_score, exp_level); end
         hold_frames(WH);
      end
      n_checks++; if (gif.score !== 14'd9999 || gif.level !== 3'd7) begin n_errors++; $display("FAIL saturation got score %0d level %0d want 9999/7", gif.score, gif.level); end
   endtask

   task automatic test_reset_mid_win();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (gif.state !== WIN) begin n_errors++; $display("FAIL pre_reset_state got %0d want 3", gif.state); end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_checks++; if (gif.state !== MENU || gif.lives !== 3'd3 || gif.level !== 3'd0 || gif.score !== 14'd0) begin
         n_errors++; $display("FAIL async_reset got state %0d lives %0d level %0d score %0d want 0/3/0/0", gif.state, gif.lives, gif.level, gif.score); end
      n_checks++; if (gif.timer !== 11'(TL) || gif.game_over !== 1'b0 || gif.frog_rst !== 1'b0) begin
         n_errors++; $display("FAIL async_reset_misc got timer %0d go %0b frog_rst %0b want %0d/0/0", gif.timer, gif.game_over, gif.frog_rst, TL); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_random();
      bit st, ft, col, rch;
      for (int c = 0; c < 3000; c++) begin
         st  = ($urandom_range(0, 19) == 0);
         ft  = ($urandom_range(0, 1) == 1);
         col = ($urandom_range(0, 29) == 0);
         rch = ($urandom_range(0, 24) == 0);
         drive(st, ft, col, rch);
         n_checks++; if (gif.state !== 2'(m_state)) begin n_errors++; $display("FAIL rnd_state c%0d got %0d want %0d", c, gif.state, m_state); end
         n_checks++; if (gif.frog_rst !== 1'(m_frog)) begin n_errors++; $display("FAIL rnd_frog_rst c%0d got %0b want %0d", c, gif.frog_rst, m_frog); end
         n_checks++; if (gif.lives !== 3'(m_lives)) begin n_errors++; $display("FAIL rnd_lives c%0d got %0d want %0d", c, gif.lives, m_lives); end
         n_checks++; if (gif.level !== 3'(m_level)) begin n_errors++; $display("FAIL rnd_level c%0d got %0d want %0d", c, gif.level, m_level); end
         n_checks++; if (gif.score !== 14'(m_score)) begin n_errors++; $display("FAIL rnd_score c%0d got %0d want %0d", c, gif.score, m_score); end
         n_checks++; if (gif.timer !== 11'(m_timer)) begin n_errors++; $display("FAIL rnd_timer c%0d got %0d want %0d", c, gif.timer, m_timer); end
         n_checks++; if (gif.game_over !== 1'(m_go)) begin n_errors++; $display("FAIL rnd_game_over c%0d got %0b want %0d", c, gif.game_over, m_go); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      gif.btn_start_tick = 1'b0;
      gif.frame_tick     = 1'b0;
      gif.collision      = 1'b0;
      gif.reached_end    = 1'b0;
      test_reset();
      test_start();
      test_death_priority();
      test_goals();
      test_timeout();
      test_game_over();
      test_score_saturation();
      test_reset_mid_win();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level game sequencer for the frogger datapath.
- Owns the MENU/PLAYING/DEAD/WIN state that drives the frog mover's `state` input, and issues one-cycle frog respawn pulses.
- Keeps lives, level, score and the per-life countdown timer.
- Sits between the button debouncers, the collision/goal detectors and the frog, lane and HUD/render blocks; advances once per video frame via `frame_tick`.

Parameters:
- LIVES, 3, lives granted at game start (1..7).
- TIME_LIMIT, 1800, frames per life before timeout (60 Hz → 30 s; max 2047).
- DEAD_HOLD, 90, frames spent in DEAD before respawn or game over (1..255).
- WIN_HOLD, 120, frames spent in WIN before the next level starts (1..255).
- MAX_LEVEL, 7, saturating level ceiling.
- GOAL_POINTS, 50, base points per goal; multiplied by (level+1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- frame_tick  in  1  one-cycle pulse per video frame
- btn_start_tick  in  1  one-cycle debounced start press
- collision  in  1  frog hit hazard (level-sensitive, sampled every cycle)
- reached_end  in  1  frog in goal row
- state  out  2  MENU=0, PLAYING=1, DEAD=2, WIN=3
- frog_rst  out  1  one-cycle respawn pulse to the frog block
- lives  out  3  remaining lives
- level  out  3  current level, 0-based; lane blocks scale speed from it
- score  out  14  score, saturating at 9999
- timer  out  11  frames left in the current life
- game_over  out  1  high in MENU after the last life is lost; cleared on start

Behaviour:
- Reset (async, `reset`=0):
  - state=MENU, frog_rst=0, lives=LIVES, level=0, score=0, timer=TIME_LIMIT, game_over=0, hold counter=0.
  - Deassertion is synchronized by the caller.
- All outputs are registered. Events sampled in cycle N are visible in cycle N+1.
- MENU:
  - btn_start_tick → PLAYING.
  - Same edge: lives=LIVES, level=0, score=0, timer=TIME_LIMIT, game_over=0, frog_rst=1.
  - All other inputs are ignored.
- PLAYING, event priority collision > reached_end > timeout. At most one event is processed per cycle.
  - Timer: decrements only on frame_tick. A frame_tick with timer==1 sets timer=0 and counts as a timeout that same cycle.
  - Death (collision or timeout):
    - lives -= 1; hold counter = DEAD_HOLD; state → DEAD.
    - lives never underflows; death at lives==1 leaves 0.
  - Goal (reached_end with no collision):
    - score += GOAL_POINTS*(level+1), saturating at 9999. Compute in ≥15 bits, then clamp.
    - level += 1, saturating at MAX_LEVEL.
    - hold counter = WIN_HOLD; state → WIN.
  - Collision and reached_end in the same cycle → death only; score unchanged.
- DEAD:
  - Hold counter decrements on frame_tick. Exit on a frame_tick with counter==1.
  - If lives>0 at exit: → PLAYING, timer=TIME_LIMIT, frog_rst=1.
  - If lives==0 at exit: → MENU, game_over=1. score and level are held for HUD display.
  - collision, reached_end and btn_start_tick are ignored.
- WIN: same hold mechanism. At exit → PLAYING, timer=TIME_LIMIT, frog_rst=1. Inputs are ignored.
- frog_rst:
  - High for exactly one cycle, on the same cycle state becomes PLAYING.
  - Never asserted on any other transition.
  - The frog already self-resets on collision, so no pulse is issued at death.
- Hold counters and timer change only on frame_tick, except for the loads on state entry.
- Reset mid-game: immediate return to reset values, regardless of state.

Decomposition:
- Package game_pkg holds:
  - game_state_t enum (MENU/PLAYING/DEAD/WIN, 2 bits, values above), shared with frog and render blocks;
  - SCORE_MAX=9999;
  - frame rate constant FRAME_HZ=60.
- Sub-module frame_countdown: parameterised-width loadable down-counter.
  - Ports: clk, reset, load, load_val, tick, count, expire (expire = tick && count==1).
  - Instantiated twice: per-life timer and DEAD/WIN hold counter.

Test Plan:
- Reset, then btn_start_tick → next cycle state=1, frog_rst=1 for one cycle only, lives=3, timer=1800; timer=1799 after the first frame_tick.
- PLAYING, pulse collision and reached_end in the same cycle → state=2, lives=2, score=0. After 90 frame_ticks → state=1, frog_rst pulse, timer=1800.
- Goal at level 0, then at level 1 → score=50 then 150, level=2. After 120 frame_ticks in WIN → PLAYING with timer reload.
- TIME_LIMIT=3: three frame_ticks with no input → DEAD on the third tick, lives decremented.
- Lose all 3 lives → after the final DEAD hold, state=0, game_over=1, score held. btn_start_tick → game_over=0, lives=3, score=0.
- Force score to 9980 and reach goal at level 2 → score=9999. Assert reset mid-WIN → state=0, all counters at reset values asynchronously.
